console_arbiter: RTL and testbench

Console I/O controller between the UART bridge (CONSOLE_IN/CONSOLE_OUT handshakes) and the processor's memory-mapped console registers. It completes the 4-phase receive handshake and buffers received characters in a small FIFO. It also shares the single transmit channel between two requesters: CPU writes and a hardware echo of received characters. The two requesters are arbitrated round-robin.

---
 rtl/console_arbiter_pkg.sv | 36 +++
 rtl/console_rx_fifo.sv | 54 +++++
 rtl/console_arbiter.sv | 154 +++++++++++++++
 tb/tb_console_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_arbiter_pkg.sv
// Shared types and constants for the console arbiter: FSM state encodings,
// transmit requester IDs and the default receive FIFO depth.
package console_arbiter_pkg;

  localparam int unsigned RX_DEPTH_DEFAULT = 4;

  // Requester IDs for the shared transmit channel
  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_ECHO = 1'b1;

  typedef enum logic [1:0] {
    RxIdle    = 2'd0,
    RxAck     = 2'd1,
    RxWaitLow = 2'd2
  } rx_state_e;

  typedef enum logic {
    TxIdle = 1'b0,
    TxSend = 1'b1
  } tx_state_e;

  // Round-robin pick; i_last is the requester granted most recently.
  function automatic logic rr_pick(input logic i_cpu_pend, input logic i_echo_pend,
                                   input logic i_last);
    logic w_pick;
    if (i_cpu_pend && i_echo_pend) begin
      w_pick = (i_last == REQ_CPU) ? REQ_ECHO : REQ_CPU;
    end else if (i_cpu_pend) begin
      w_pick = REQ_CPU;
    end else begin
      w_pick = REQ_ECHO;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/console_rx_fifo.sv
// Receive character FIFO: power-of-two depth, extra pointer bit distinguishes
// full from empty, head is read combinationally from storage.
module console_rx_fifo
  import console_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = RX_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (w_count == FULL_COUNT);
  assign o_empty   = (w_count == '0);
  // Full is judged on the pre-pop count, so a pop never frees room in its own cycle
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mem    <= '{default: '0};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/console_arbiter.sv
// Console I/O controller: 4-phase receive handshake into a small FIFO, and a
// round-robin shared transmit channel for CPU writes and hardware echo.
module console_arbiter
  import console_arbiter_pkg::*;
#(
  parameter int unsigned RX_DEPTH = RX_DEPTH_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_console_in,
  input  logic       i_console_in_valid,
  output logic       o_console_in_ack,
  output logic [7:0] o_console_out,
  output logic       o_console_out_valid,
  input  logic       i_console_out_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_we,
  output logic       o_tx_busy,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_re,
  input  logic       i_echo_en
);

  rx_state_e  r_rx_state;
  rx_state_e  w_rx_state_d;
  tx_state_e  r_tx_state;
  tx_state_e  w_tx_state_d;

  logic       w_push;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;

  logic       r_cpu_pend;
  logic [7:0] r_cpu_data;
  logic       r_echo_pend;
  logic [7:0] r_echo_data;
  logic       r_rr;
  logic       r_grant;
  logic       w_grant_d;
  logic [7:0] r_out_data;
  logic       w_tx_load;
  logic       w_tx_done;

  console_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (i_console_in),
    .i_pop   (i_rx_re),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_push       = 1'b0;
    case (r_rx_state)
      RxIdle: begin
        if (i_console_in_valid && !w_full) begin
          w_push       = 1'b1;
          w_rx_state_d = RxAck;
        end
      end
      RxAck:     w_rx_state_d = RxWaitLow;
      RxWaitLow: begin
        if (!i_console_in_valid) begin
          w_rx_state_d = RxIdle;
        end
      end
      default:   w_rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_load    = 1'b0;
    w_tx_done    = 1'b0;
    w_grant_d    = r_grant;
    case (r_tx_state)
      TxIdle: begin
        if (r_cpu_pend || r_echo_pend) begin
          w_tx_load    = 1'b1;
          w_grant_d    = rr_pick(r_cpu_pend, r_echo_pend, r_rr);
          w_tx_state_d = TxSend;
        end
      end
      TxSend: begin
        if (i_console_out_ready) begin
          w_tx_done    = 1'b1;
          w_tx_state_d = TxIdle;
        end
      end
      default: w_tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_state <= RxIdle;
      r_tx_state <= TxIdle;
      r_grant    <= REQ_CPU;
      // Pretend echo was served last so the CPU wins the first tie
      r_rr       <= REQ_ECHO;
      r_out_data <= '0;
    end else begin
      r_rx_state <= w_rx_state_d;
      r_tx_state <= w_tx_state_d;
      if (w_tx_load) begin
        r_grant    <= w_grant_d;
        r_out_data <= (w_grant_d == REQ_CPU) ? r_cpu_data : r_echo_data;
      end
      if (w_tx_done) begin
        r_rr <= r_grant;
      end
    end
  end

  // Pends are only set from clear and only cleared from set, so set/clear never collide
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cpu_pend  <= 1'b0;
      r_cpu_data  <= '0;
      r_echo_pend <= 1'b0;
      r_echo_data <= '0;
    end else begin
      if (i_tx_we && !r_cpu_pend) begin
        r_cpu_pend <= 1'b1;
        r_cpu_data <= i_tx_data;
      end else if (w_tx_done && (r_grant == REQ_CPU)) begin
        r_cpu_pend <= 1'b0;
      end
      if (w_push && i_echo_en && !r_echo_pend) begin
        r_echo_pend <= 1'b1;
        r_echo_data <= i_console_in;
      end else if (w_tx_done && (r_grant == REQ_ECHO)) begin
        r_echo_pend <= 1'b0;
      end
    end
  end

  assign o_console_in_ack    = (r_rx_state == RxAck);
  assign o_console_out       = r_out_data;
  assign o_console_out_valid = (r_tx_state == TxSend);
  assign o_tx_busy           = r_cpu_pend;
  assign o_rx_data           = w_head;
  assign o_rx_valid          = ~w_empty;

endmodule

// File: tb/tb_console_arbiter.sv
// Bench for console_arbiter: directed scenarios plus random traffic, checked by a
// queue-based reference model and a scoreboard monitor on the transmit channel.
module tb_console_arbiter;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_we = 1'b0;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_re = 1'b0;
  logic       echo_en = 1'b0;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0] m_fifo[$];
  int         m_rx_phase;   // 0 waiting for char, 1 ack cycle, 2 waiting for valid low
  bit         m_cpu_pend, m_echo_pend, m_sending, m_who, m_last;
  logic [7:0] m_cpu_data, m_echo_data, m_out;
  bit         m_full, m_cap, m_pop, m_xfer, m_old_cpu, m_old_echo;
  logic [7:0] exp_q[$];
  logic [7:0] sent_log[$];
  bit         prev_valid;
  logic [7:0] prev_data;
  bit         src_done;
  int         dummy;

  always #5 clk = ~clk;

  console_arbiter #(
    .RX_DEPTH (DEPTH)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_console_in        (in_data),
    .i_console_in_valid  (in_valid),
    .o_console_in_ack    (in_ack),
    .o_console_out       (out_data),
    .o_console_out_valid (out_valid),
    .i_console_out_ready (out_ready),
    .i_tx_data           (tx_data),
    .i_tx_we             (tx_we),
    .o_tx_busy           (tx_busy),
    .o_rx_data           (rx_data),
    .o_rx_valid          (rx_valid),
    .i_rx_re             (rx_re),
    .i_echo_en           (echo_en)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_rx_phase  = 0;
    m_cpu_pend  = 0;
    m_echo_pend = 0;
    m_sending   = 0;
    m_who       = 0;
    m_last      = 1;  // echo served last: CPU wins first tie
    m_cpu_data  = '0;
    m_echo_data = '0;
    m_out       = '0;
  endtask

  // Drive one character through the receive handshake; counts cycles with ack high.
  task automatic send_char(input logic [7:0] d, input int linger, input bit with_we,
                           input logic [7:0] wd, output int acks);
    bit got;
    got  = 0;
    acks = 0;
    in_data  = d;
    in_valid = 1'b1;
    if (with_we) begin
      tx_we   = 1'b1;
      tx_data = wd;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (with_we) tx_we = 1'b0;
      if (in_ack) begin
        got = 1;
        acks++;
      end
    end
    chk("rx_ack_seen", got, 1);
    tick();
    if (in_ack) acks++;
    repeat (linger) begin
      tick();
      if (in_ack) acks++;
    end
    in_valid = 1'b0;
    tick();
    if (in_ack) acks++;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    tx_we   = 1'b1;
    tx_data = d;
    tick();
    tx_we   = 1'b0;
  endtask

  task automatic wait_log(input int base, input int n, input string name);
    for (int i = 0; i < 100 && sent_log.size() < base + n; i++) tick();
    repeat (4) tick();
    chk(name, sent_log.size() - base, n);
  endtask

  initial begin
    model_reset();
    prev_valid = 0;
    prev_data  = '0;
    src_done   = 0;
    fork
      // Reference model: advances on each edge from the inputs applied before it
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          model_reset();
        end else begin
          m_full     = (m_fifo.size() == DEPTH);
          m_cap      = (m_rx_phase == 0) && in_valid && !m_full;
          m_pop      = rx_re && (m_fifo.size() != 0);
          m_xfer     = m_sending && out_ready;
          m_old_cpu  = m_cpu_pend;
          m_old_echo = m_echo_pend;
          if (m_pop) void'(m_fifo.pop_front());
          if (m_cap) m_fifo.push_back(in_data);
          if (m_rx_phase == 0 && m_cap) m_rx_phase = 1;
          else if (m_rx_phase == 1) m_rx_phase = 2;
          else if (m_rx_phase == 2 && !in_valid) m_rx_phase = 0;
          if (m_xfer) begin
            m_sending = 0;
            m_last    = m_who;
            if (m_who) m_echo_pend = 0;
            else m_cpu_pend = 0;
          end else if (!m_sending && (m_old_cpu || m_old_echo)) begin
            m_who     = (m_old_cpu && m_old_echo) ? !m_last : !m_old_cpu;
            m_out     = m_who ? m_echo_data : m_cpu_data;
            m_sending = 1;
            exp_q.push_back(m_out);
          end
          if (tx_we && !m_old_cpu) begin
            m_cpu_pend = 1;
            m_cpu_data = tx_data;
          end
          if (m_cap && echo_en && !m_old_echo) begin
            m_echo_pend = 1;
            m_echo_data = in_data;
          end
        end
      end
      // Monitor / scoreboard, sampling on the falling edge
      forever begin
        @(negedge clk);
        chk("ack", in_ack, m_rx_phase == 1);
        chk("rx_valid", rx_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) chk("rx_head", rx_data, m_fifo[0]);
        chk("tx_busy", tx_busy, m_cpu_pend);
        chk("out_valid", out_valid, m_sending);
        if (out_valid && prev_valid) chk("out_stable", out_data, prev_data);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_extra: got 0x%0h expected nothing at %0t", out_data, $time);
          end else begin
            chk("tx_data", out_data, exp_q.pop_front());
          end
          sent_log.push_back(out_data);
        end
        prev_valid = out_valid;
        prev_data  = out_data;
      end
      // Watchdog
      begin
        repeat (60000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
      end
      // Stimulus
      begin
        int acks;
        int base;
        logic [7:0] seq_exp[5];
        seq_exp = '{8'h57, 8'h0D, 8'h58, 8'h0A, 8'h59};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", in_ack, 0);
        chk("rst_out", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;

        // Single receive with lingering valid
        send_char(8'h41, 3, 0, 8'h00, acks);
        chk("single_ack_width", acks, 1);
        chk("single_rx_valid", rx_valid, 1);
        chk("single_rx_data", rx_data, 8'h41);
        rx_re = 1'b1;
        tick();
        rx_re = 1'b0;
        chk("single_one_push", rx_valid, 0);

        // FIFO full backpressure on the receive side
        for (int i = 0; i < 4; i++) send_char(8'h50 + 8'(i), 0, 0, 8'h00, acks);
        in_data  = 8'h54;
        in_valid = 1'b1;
        acks     = 0;
        repeat (6) begin
          tick();
          if (in_ack) acks++;
        end
        chk("full_no_ack", acks, 0);
        chk("full_head", rx_data, 8'h50);
        rx_re = 1'b1;
        tick();
        rx_re = 1'b0;
        chk("full_push_blocked_on_pop", in_ack, 0);
        acks = 0;
        for (int i = 0; i < 20 && acks == 0; i++) begin
          tick();
          if (in_ack) acks++;
        end
        chk("full_ack_after_pop", acks, 1);
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
          chk("full_pop_order", rx_data, 8'h51 + 8'(i));
          rx_re = 1'b1;
          tick();
        end
        rx_re = 1'b0;
        chk("full_drained", rx_valid, 0);

        // Echo vs CPU contention
        echo_en = 1'b1;
        base = sent_log.size();
        send_char(8'h0D, 0, 1, 8'h57, acks);
        wait_log(base, 2, "pair1_count");
        cpu_write(8'h58);
        wait_log(base + 2, 1, "lone_cpu_count");
        send_char(8'h0A, 0, 1, 8'h59, acks);
        wait_log(base + 3, 2, "pair2_count");
        for (int i = 0; i < 5; i++) begin
          if (sent_log.size() > base + i) chk("rr_order", sent_log[base + i], seq_exp[i]);
        end
        echo_en = 1'b0;
        rx_re = 1'b1;
        repeat (DEPTH + 1) tick();
        rx_re = 1'b0;

        // Transmit backpressure
        out_ready = 1'b0;
        base = sent_log.size();
        cpu_write(8'h43);
        tick();
        for (int i = 0; i < 10; i++) begin
          chk("bp_valid", out_valid, 1);
          chk("bp_data", out_data, 8'h43);
          chk("bp_busy", tx_busy, 1);
          tx_we   = (i == 3);
          tx_data = 8'h44;
          tick();
        end
        tx_we = 1'b0;
        out_ready = 1'b1;
        wait_log(base, 1, "bp_one_transfer");
        if (sent_log.size() > base) chk("bp_sent_data", sent_log[base], 8'h43);
        chk("bp_busy_clear", tx_busy, 0);

        // Random traffic
        fork
          begin
            for (int n = 0; n < 60; n++) begin
              repeat ($urandom_range(0, 4)) tick();
              send_char(8'($urandom), int'($urandom_range(0, 3)), 0, 8'h00, dummy);
            end
            src_done = 1;
          end
          while (!src_done) begin
            rx_re = ($urandom_range(0, 3) == 0);
            tick();
          end
          while (!src_done) begin
            tx_we   = ($urandom_range(0, 5) == 0);
            tx_data = 8'($urandom);
            tick();
          end
          while (!src_done) begin
            out_ready = ($urandom_range(0, 2) != 0);
            echo_en   = $urandom_range(0, 1) == 1;
            tick();
          end
        join
        tx_we     = 1'b0;
        echo_en   = 1'b0;
        out_ready = 1'b1;
        rx_re     = 1'b1;
        repeat (20) tick();
        rx_re = 1'b0;
        chk("rand_drain_tx", exp_q.size(), 0);
        chk("rand_drain_rx", rx_valid, 0);

        // Reset in the middle of a send with buffered characters
        out_ready = 1'b0;
        send_char(8'h71, 0, 0, 8'h00, acks);
        send_char(8'h72, 0, 0, 8'h00, acks);
        cpu_write(8'h61);
        tick();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_rx_valid", rx_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", in_ack, 0);
        chk("mid_rst_out", out_data, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        base = sent_log.size();
        cpu_write(8'h62);
        wait_log(base, 1, "post_rst_count");
        if (sent_log.size() > base) chk("post_rst_data", sent_log[base], 8'h62);
        chk("post_rst_busy", tx_busy, 0);
        chk("final_scoreboard_empty", exp_q.size(), 0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
